// File: rtl/register_file_rename_pkg.sv
// Shared widths and types for the renaming architectural register file.
package register_file_rename_pkg;

    localparam int REG_NUM     = 32;
    localparam int XLEN        = 32;
    localparam int ENTRY_WIDTH = 5;
    localparam int REG_AW      = 5;

    typedef logic [XLEN-1:0]        word_t;
    typedef logic [ENTRY_WIDTH-1:0] tag_t;
    typedef logic [REG_AW-1:0]      reg_idx_t;

endpackage

// File: rtl/register_file_rename_reg_read_port.sv
// One source-operand lookup: commit bypass onto a pending register, x0 masking,
// and the wait-entry output forced to zero when the operand is ready.
module register_file_rename_reg_read_port
    import register_file_rename_pkg::*;
(
    input  logic [REG_AW-1:0]      i_addr,
    input  logic [XLEN-1:0]        i_stored_value,
    input  logic                   i_stored_busy,
    input  logic [ENTRY_WIDTH-1:0] i_stored_tag,
    input  logic                   i_commit_valid,
    input  logic [REG_AW-1:0]      i_commit_rd,
    input  logic [ENTRY_WIDTH-1:0] i_commit_entry,
    input  logic [XLEN-1:0]        i_commit_value,
    output logic [XLEN-1:0]        o_value,
    output logic                   o_busy,
    output logic [ENTRY_WIDTH-1:0] o_entry
);

    logic w_is_x0;
    logic w_bypass;

    assign w_is_x0  = (i_addr == '0);
    assign w_bypass = i_commit_valid && (i_commit_rd == i_addr) && !w_is_x0
                      && i_stored_busy && (i_stored_tag == i_commit_entry);

    always_comb begin
        o_value = i_stored_value;
        o_busy  = i_stored_busy;
        o_entry = i_stored_busy ? i_stored_tag : '0;
        if (w_is_x0) begin
            o_value = '0;
            o_busy  = 1'b0;
            o_entry = '0;
        end else if (w_bypass) begin
            o_value = i_commit_value;
            o_busy  = 1'b0;
            o_entry = '0;
        end
    end

endmodule

// File: rtl/register_file_rename.sv
// Architectural register file with per-register ROB rename tags: issue marks a
// register pending on a ROB entry, commit writes the value and clears the tag.
module register_file_rename
    import register_file_rename_pkg::*;
(
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   roll_back,
    input  logic                   issue_valid,
    input  logic [REG_AW-1:0]      issue_rd,
    input  logic [ENTRY_WIDTH-1:0] issue_entry,
    input  logic                   commit_valid,
    input  logic [REG_AW-1:0]      commit_rd,
    input  logic [ENTRY_WIDTH-1:0] commit_entry,
    input  logic [XLEN-1:0]        commit_value,
    input  logic [REG_AW-1:0]      rs1_addr,
    output logic [XLEN-1:0]        rs1_value,
    output logic                   rs1_busy,
    output logic [ENTRY_WIDTH-1:0] rs1_entry,
    input  logic [REG_AW-1:0]      rs2_addr,
    output logic [XLEN-1:0]        rs2_value,
    output logic                   rs2_busy,
    output logic [ENTRY_WIDTH-1:0] rs2_entry
);

    logic [XLEN-1:0]        r_value [REG_NUM];
    logic [ENTRY_WIDTH-1:0] r_tag   [REG_NUM];
    logic [REG_NUM-1:0]     r_busy;

    logic w_issue_we;
    logic w_commit_we;
    logic w_commit_clears;

    assign w_issue_we  = issue_valid  && (issue_rd  != '0);
    assign w_commit_we = commit_valid && (commit_rd != '0);
    // A same-cycle issue to the committing register leaves a younger writer pending.
    assign w_commit_clears = w_commit_we && (r_tag[commit_rd] == commit_entry)
                             && !(w_issue_we && (issue_rd == commit_rd));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                r_value[i] <= '0;
                r_tag[i]   <= '0;
            end
        end else if (rdy_in) begin
            if (roll_back) begin
                r_busy <= '0;
                for (int i = 0; i < REG_NUM; i++) begin
                    r_tag[i] <= '0;
                end
            end else begin
                if (w_commit_we) begin
                    r_value[commit_rd] <= commit_value;
                end
                if (w_commit_clears) begin
                    r_busy[commit_rd] <= 1'b0;
                end
                if (w_issue_we) begin
                    r_busy[issue_rd] <= 1'b1;
                    r_tag[issue_rd]  <= issue_entry;
                end
            end
        end
    end

    register_file_rename_reg_read_port u_rd_port1 (
        .i_addr         (rs1_addr),
        .i_stored_value (r_value[rs1_addr]),
        .i_stored_busy  (r_busy[rs1_addr]),
        .i_stored_tag   (r_tag[rs1_addr]),
        .i_commit_valid (commit_valid),
        .i_commit_rd    (commit_rd),
        .i_commit_entry (commit_entry),
        .i_commit_value (commit_value),
        .o_value        (rs1_value),
        .o_busy         (rs1_busy),
        .o_entry        (rs1_entry)
    );

    register_file_rename_reg_read_port u_rd_port2 (
        .i_addr         (rs2_addr),
        .i_stored_value (r_value[rs2_addr]),
        .i_stored_busy  (r_busy[rs2_addr]),
        .i_stored_tag   (r_tag[rs2_addr]),
        .i_commit_valid (commit_valid),
        .i_commit_rd    (commit_rd),
        .i_commit_entry (commit_entry),
        .i_commit_value (commit_value),
        .o_value        (rs2_value),
        .o_busy         (rs2_busy),
        .o_entry        (rs2_entry)
    );

endmodule

// File: tb/tb_register_file_rename.sv
// Directed bench for register_file_rename with hand-computed expectations.
module tb_register_file_rename;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        roll_back;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  issue_entry;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [4:0]  commit_entry;
    logic [31:0] commit_value;
    logic [4:0]  rs1_addr;
    logic [31:0] rs1_value;
    logic        rs1_busy;
    logic [4:0]  rs1_entry;
    logic [4:0]  rs2_addr;
    logic [31:0] rs2_value;
    logic        rs2_busy;
    logic [4:0]  rs2_entry;

    int n_checks = 0;
    int n_fail   = 0;

    register_file_rename dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .roll_back    (roll_back),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_entry  (issue_entry),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_entry (commit_entry),
        .commit_value (commit_value),
        .rs1_addr     (rs1_addr),
        .rs1_value    (rs1_value),
        .rs1_busy     (rs1_busy),
        .rs1_entry    (rs1_entry),
        .rs2_addr     (rs2_addr),
        .rs2_value    (rs2_value),
        .rs2_busy     (rs2_busy),
        .rs2_entry    (rs2_entry)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        issue_valid  = 1'b0;
        commit_valid = 1'b0;
        roll_back    = 1'b0;
        #1;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [4:0] tag);
        issue_valid = 1'b1; issue_rd = rd; issue_entry = tag;
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [4:0] tag, input logic [31:0] val);
        commit_valid = 1'b1; commit_rd = rd; commit_entry = tag; commit_value = val;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b1; roll_back = 1'b0;
        issue_valid = 1'b0; issue_rd = '0; issue_entry = '0;
        commit_valid = 1'b0; commit_rd = '0; commit_entry = '0; commit_value = '0;
        rs1_addr = 5'd5; rs2_addr = 5'd6;
        #2;
        n_checks++; if (rs1_value !== 32'd0 || rs1_busy !== 1'b0 || rs1_entry !== 5'd0) begin n_fail++; $display("FAIL reset_state: got %h/%b/%0d exp 0/0/0", rs1_value, rs1_busy, rs1_entry); end
        step(); step();
        rst_in = 1'b0;
        do_commit(5'd6, 5'd0, 32'h0000_00AB);
        step(); idle();
        do_issue(5'd5, 5'd3);
        step(); idle();
        n_checks++; if (rs1_busy !== 1'b1 || rs1_entry !== 5'd3) begin n_fail++; $display("FAIL pre_reset_busy: got %b/%0d exp 1/3", rs1_busy, rs1_entry); end
        n_checks++; if (rs2_value !== 32'h0000_00AB) begin n_fail++; $display("FAIL pre_reset_value: got %h exp 000000ab", rs2_value); end
        #2;
        rst_in = 1'b1;
        #1;
        n_checks++; if (rs1_value !== 32'd0 || rs1_busy !== 1'b0 || rs1_entry !== 5'd0) begin n_fail++; $display("FAIL async_reset_x5: got %h/%b/%0d exp 0/0/0", rs1_value, rs1_busy, rs1_entry); end
        n_checks++; if (rs2_value !== 32'd0) begin n_fail++; $display("FAIL async_reset_x6: got %h exp 0", rs2_value); end
        step();
        rst_in = 1'b0;
    endtask

    task automatic test_rename_commit();
        rs1_addr = 5'd5;
        do_issue(5'd5, 5'd3);
        step(); idle();
        n_checks++; if (rs1_busy !== 1'b1 || rs1_entry !== 5'd3) begin n_fail++; $display("FAIL rename_busy: got %b/%0d exp 1/3", rs1_busy, rs1_entry); end
        do_commit(5'd5, 5'd3, 32'hDEAD_BEEF);
        #1;
        n_checks++; if (rs1_value !== 32'hDEAD_BEEF || rs1_busy !== 1'b0 || rs1_entry !== 5'd0) begin n_fail++; $display("FAIL commit_bypass: got %h/%b/%0d exp deadbeef/0/0", rs1_value, rs1_busy, rs1_entry); end
        step(); idle();
        n_checks++; if (rs1_value !== 32'hDEAD_BEEF || rs1_busy !== 1'b0 || rs1_entry !== 5'd0) begin n_fail++; $display("FAIL commit_stored: got %h/%b/%0d exp deadbeef/0/0", rs1_value, rs1_busy, rs1_entry); end
    endtask

    task automatic test_younger_writer();
        rs1_addr = 5'd7;
        do_issue(5'd7, 5'd2); step();
        do_issue(5'd7, 5'd4); step(); idle();
        do_commit(5'd7, 5'd2, 32'h11);
        #1;
        n_checks++; if (rs1_busy !== 1'b1 || rs1_entry !== 5'd4) begin n_fail++; $display("FAIL stale_commit_no_bypass: got %b/%0d exp 1/4", rs1_busy, rs1_entry); end
        step(); idle();
        n_checks++; if (rs1_busy !== 1'b1 || rs1_entry !== 5'd4 || rs1_value !== 32'h11) begin n_fail++; $display("FAIL younger_pending: got %b/%0d/%h exp 1/4/00000011", rs1_busy, rs1_entry, rs1_value); end
        do_commit(5'd7, 5'd4, 32'h22);
        step(); idle();
        n_checks++; if (rs1_busy !== 1'b0 || rs1_entry !== 5'd0 || rs1_value !== 32'h22) begin n_fail++; $display("FAIL younger_commit: got %b/%0d/%h exp 0/0/00000022", rs1_busy, rs1_entry, rs1_value); end
    endtask

    task automatic test_same_cycle();
        rs2_addr = 5'd9;
        do_issue(5'd9, 5'd1); step(); idle();
        do_commit(5'd9, 5'd1, 32'h55);
        do_issue(5'd9, 5'd6);
        #1;
        n_checks++; if (rs2_busy !== 1'b0 || rs2_value !== 32'h55 || rs2_entry !== 5'd0) begin n_fail++; $display("FAIL same_cycle_read: got %b/%h/%0d exp 0/00000055/0", rs2_busy, rs2_value, rs2_entry); end
        step(); idle();
        n_checks++; if (rs2_busy !== 1'b1 || rs2_entry !== 5'd6 || rs2_value !== 32'h55) begin n_fail++; $display("FAIL issue_wins: got %b/%0d/%h exp 1/6/00000055", rs2_busy, rs2_entry, rs2_value); end
    endtask

    task automatic test_x0_rollback();
        rs1_addr = 5'd0;
        do_issue(5'd0, 5'd8);
        do_commit(5'd0, 5'd0, 32'h99);
        #1;
        n_checks++; if (rs1_value !== 32'd0 || rs1_busy !== 1'b0 || rs1_entry !== 5'd0) begin n_fail++; $display("FAIL x0_same_cycle: got %h/%b/%0d exp 0/0/0", rs1_value, rs1_busy, rs1_entry); end
        step(); idle();
        n_checks++; if (rs1_value !== 32'd0 || rs1_busy !== 1'b0 || rs1_entry !== 5'd0) begin n_fail++; $display("FAIL x0_after: got %h/%b/%0d exp 0/0/0", rs1_value, rs1_busy, rs1_entry); end
        do_commit(5'd1, 5'd0, 32'h101); step(); idle();
        do_issue(5'd1, 5'd11); step();
        do_issue(5'd2, 5'd12); step();
        do_issue(5'd3, 5'd13); step(); idle();
        rs1_addr = 5'd1; rs2_addr = 5'd3;
        #1;
        n_checks++; if (rs1_busy !== 1'b1 || rs1_entry !== 5'd11 || rs2_busy !== 1'b1 || rs2_entry !== 5'd13) begin n_fail++; $display("FAIL renamed_x1_x3: got %b/%0d %b/%0d exp 1/11 1/13", rs1_busy, rs1_entry, rs2_busy, rs2_entry); end
        roll_back = 1'b1;
        do_commit(5'd2, 5'd12, 32'h77);
        step(); idle();
        n_checks++; if (rs1_busy !== 1'b0 || rs1_entry !== 5'd0 || rs1_value !== 32'h101) begin n_fail++; $display("FAIL rollback_x1: got %b/%0d/%h exp 0/0/00000101", rs1_busy, rs1_entry, rs1_value); end
        n_checks++; if (rs2_busy !== 1'b0 || rs2_entry !== 5'd0) begin n_fail++; $display("FAIL rollback_x3: got %b/%0d exp 0/0", rs2_busy, rs2_entry); end
        rs2_addr = 5'd2;
        #1;
        n_checks++; if (rs2_busy !== 1'b0 || rs2_value !== 32'd0) begin n_fail++; $display("FAIL rollback_drops_commit: got %b/%h exp 0/00000000", rs2_busy, rs2_value); end
    endtask

    task automatic test_rdy();
        rs1_addr = 5'd4;
        rdy_in = 1'b0;
        do_issue(5'd4, 5'd10);
        step(); step(); step();
        n_checks++; if (rs1_busy !== 1'b0 || rs1_entry !== 5'd0) begin n_fail++; $display("FAIL rdy_low_frozen: got %b/%0d exp 0/0", rs1_busy, rs1_entry); end
        rdy_in = 1'b1;
        #1;
        n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL rdy_high_before_edge: got %b exp 0", rs1_busy); end
        step(); idle();
        n_checks++; if (rs1_busy !== 1'b1 || rs1_entry !== 5'd10) begin n_fail++; $display("FAIL rdy_resume: got %b/%0d exp 1/10", rs1_busy, rs1_entry); end
    endtask

    initial begin
        test_reset();
        test_rename_commit();
        test_younger_writer();
        test_same_cycle();
        test_x0_rollback();
        test_rdy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file_rename.md
Name: register_file_rename

Overview:
- Architectural register file with per-register rename tags. Sits downstream of the reorder buffer.
- At issue it records which ROB entry will produce each destination register.
- At ROB commit it writes the result and clears the busy tag.
- It serves the decoder/dispatch with two source-operand lookups: value, or the ROB entry to wait on.

Parameters:
- REG_NUM, 32, number of architectural registers; x0 is hard-wired to zero.
- XLEN, 32, data width.
- ENTRY_WIDTH, 5, ROB entry tag width; must match ROB_SIZE = 32.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-high reset
- rdy_in  input  1  pause when low; all state frozen
- roll_back  input  1  mispredict flush
- issue_valid  input  1  an instruction is entering the ROB this cycle
- issue_rd  input  5  destination register of the issuing instruction
- issue_entry  input  ENTRY_WIDTH  ROB entry allocated to it (ROB cur_entry)
- commit_valid  input  1  ROB rob_commit
- commit_rd  input  5  destination register of the committing instruction
- commit_entry  input  ENTRY_WIDTH  ROB rob_entry_commit
- commit_value  input  XLEN  ROB rob_result_out
- rs1_addr  input  5  source 1 index
- rs1_value  output  XLEN  source 1 value, valid when rs1_busy = 0
- rs1_busy  output  1  source 1 still pending in the ROB
- rs1_entry  output  ENTRY_WIDTH  ROB entry to wait on when busy
- rs2_addr, rs2_value, rs2_busy, rs2_entry: same as source 1, for source 2.

Behaviour:
- State per register: value[XLEN], busy, tag[ENTRY_WIDTH].
- Reset: asynchronous, active-high. All values, busy bits and tags are cleared to 0. Read outputs are combinational, so they read 0/0/0 during reset.
- rdy_in low (and not reset): no state changes. Reads remain combinational on the current state.
- roll_back (synchronous, priority over issue and commit):
  - Clear every busy bit and tag.
  - Values are retained.
  - The same-cycle commit is discarded, because the ROB suppresses commit on roll_back.
- Commit, when commit_valid and commit_rd != 0:
  - value[commit_rd] <= commit_value unconditionally; commit order is program order.
  - busy[commit_rd] <= 0 only if tag[commit_rd] == commit_entry and no same-cycle issue targets commit_rd.
  - Otherwise busy and tag are untouched; a younger writer is still pending.
- Issue, when issue_valid and issue_rd != 0: busy[issue_rd] <= 1 and tag[issue_rd] <= issue_entry, next edge.
- Simultaneous issue and commit to the same rd: issue wins for busy/tag; commit still writes the value.
- x0: never written, never busy. Reads of 0 return value 0, busy 0, entry 0.
- Read, combinational, per port, with commit bypass:
  - If commit_valid, commit_rd == addr != 0, busy[addr] = 1 and tag[addr] == commit_entry: return value = commit_value, busy = 0.
  - Else return the stored value, busy and tag.
  - entry output = tag when busy, else 0.
  - Same-cycle issue is NOT visible to reads. An instruction's sources see the mapping before its own rename.
- Latency: write visible to reads one edge after issue/commit, or zero-cycle via the commit bypass.
- Tag width wrap: entries reuse 0..31. A stale tag match is impossible because the ROB holds at most 31 in flight.

Decomposition:
- Shared header operaType.v provides `ENTRY_RANGE, `TRUE and `FALSE. Add `REG_RANGE [4:0] there.
- One sub-module is natural: reg_read_port, the bypass mux plus x0 masking, instantiated twice.
- The register arrays stay in the top module.

Test Plan:
- Reset mid-operation: issue x5 tag 3, then assert rst_in asynchronously between edges → rs1_addr=5 reads value 0, busy 0 immediately, without waiting for a clock edge.
- Rename then commit: issue x5 tag 3 → rs1 busy 1, entry 3. Commit x5 tag 3 value 0xDEADBEEF → same-cycle read 0xDEADBEEF busy 0 (bypass); next cycle same, from storage.
- Younger writer: issue x7 tag 2, issue x7 tag 4, commit x7 tag 2 value 0x11 → x7 stays busy, entry 4, stored value 0x11. Commit tag 4 value 0x22 → busy 0, value 0x22.
- Same-cycle issue/commit to x9: pending tag 1, commit tag 1 value 0x55 while issuing x9 tag 6 → same-cycle read busy 0, value 0x55; next cycle busy 1, entry 6, value 0x55.
- x0 and roll_back: issue x0 tag 8 and commit x0 value 0x99 → x0 reads 0, busy 0. Rename x1..x3, assert roll_back → all read busy 0 with prior values.
- rdy_in low: hold issue x4 tag 10 with rdy_in=0 for 3 cycles → x4 not busy. Raise rdy_in → busy, entry 10 after the next edge.
